// File: rtl/reg_hex_display_pkg.sv
// Shared constants for the register hex display: digit count, anode/segment
// idle patterns and the active-low gfedcba glyph table for hex digits 0..F.
package reg_hex_display_pkg;

  // Number of multiplexed digits; a 16-bit value is shown as 4 nibbles.
  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = $clog2(NUM_DIGITS);
  localparam int NIBBLE_W   = 4;
  localparam int VALUE_W    = NUM_DIGITS * NIBBLE_W;
  localparam int NUM_REGS   = 8;
  localparam int SEL_W      = $clog2(NUM_REGS);

  // Anodes are active-low: all ones means every digit is dark.
  localparam logic [NUM_DIGITS-1:0] AN_ALL_OFF = '1;

  // Segments are active-low: all ones means every segment is dark.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Glyphs in gfedcba order, active-low, indexed by nibble value.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

  // Glyph of the "0" digit, which is also what the display shows out of reset.
  localparam logic [6:0] SEG_ZERO = 7'b1000000;

  // Map one nibble to its active-low segment pattern.
  function automatic logic [6:0] hex_to_seg(input logic [NIBBLE_W-1:0] nibble);
    return HEX_SEG[nibble];
  endfunction

endpackage

// File: rtl/reg_hex_display_btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter and a
// one-cycle pulse on each accepted press (rising edge of the stable level).
module reg_hex_display_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_raw,
  output logic press_pulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_reg;
  logic             btn_s_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             stable_reg;
  logic             stable_next;
  logic             stable_d_reg;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1_reg <= 1'b0;
      btn_s_reg <= 1'b0;
    end else begin
      sync1_reg <= btn_raw;
      btn_s_reg <= sync1_reg;
    end
  end

  // Count while the synchronised level disagrees with the accepted level;
  // accept the new level once it has held for DEBOUNCE_CYCLES samples.
  always_comb begin
    cnt_next    = '0;
    stable_next = stable_reg;
    if (btn_s_reg != stable_reg) begin
      if (cnt_reg == CNT_LAST) begin
        stable_next = btn_s_reg;
      end else begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
    end
  end

  // Debounce state registers, plus a delayed copy for edge detection.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_reg      <= '0;
      stable_reg   <= 1'b0;
      stable_d_reg <= 1'b0;
    end else begin
      cnt_reg      <= cnt_next;
      stable_reg   <= stable_next;
      stable_d_reg <= stable_reg;
    end
  end

  // Only presses count; a release (falling edge) produces nothing.
  assign press_pulse = stable_reg & ~stable_d_reg;

endmodule

// File: rtl/reg_hex_display.sv
// Shows one of eight 16-bit CPU debug registers as four hex digits on a
// multiplexed common-anode 7-segment display. A debounced button steps the
// selected register; hold freezes the value; a per-frame snapshot keeps the
// four digits of one frame consistent with each other.
module reg_hex_display
  import reg_hex_display_pkg::*;
#(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [VALUE_W-1:0]    r0,
  input  logic [VALUE_W-1:0]    r1,
  input  logic [VALUE_W-1:0]    r2,
  input  logic [VALUE_W-1:0]    r3,
  input  logic [VALUE_W-1:0]    r4,
  input  logic [VALUE_W-1:0]    r5,
  input  logic [VALUE_W-1:0]    r6,
  input  logic [VALUE_W-1:0]    r7,
  input  logic                  sel_btn,
  input  logic                  hold,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [SEL_W-1:0]      reg_sel
);

  localparam int PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
  localparam logic [DIGIT_W-1:0] DIGIT_LAST = DIGIT_W'(NUM_DIGITS - 1);

  // ---------------------------------------------------------------------
  // Register bank view of the debug inputs
  // ---------------------------------------------------------------------
  logic [VALUE_W-1:0] reg_bank [NUM_REGS];

  assign reg_bank[0] = r0;
  assign reg_bank[1] = r1;
  assign reg_bank[2] = r2;
  assign reg_bank[3] = r3;
  assign reg_bank[4] = r4;
  assign reg_bank[5] = r5;
  assign reg_bank[6] = r6;
  assign reg_bank[7] = r7;

  // ---------------------------------------------------------------------
  // Button conditioning
  // ---------------------------------------------------------------------
  logic press_pulse;

  reg_hex_display_btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clock      (clock),
    .reset      (reset),
    .btn_raw    (sel_btn),
    .press_pulse(press_pulse)
  );

  // ---------------------------------------------------------------------
  // Scan timing
  // ---------------------------------------------------------------------
  logic [PRESC_W-1:0] presc_reg;
  logic [PRESC_W-1:0] presc_next;
  logic [DIGIT_W-1:0] digit_reg;
  logic [DIGIT_W-1:0] digit_next;
  logic               scan_tc;
  logic               frame_end;

  // Prescaler wraps every SCAN_DIV cycles and then moves to the next digit;
  // the digit counter wraps naturally because NUM_DIGITS is a power of two.
  always_comb begin
    scan_tc    = (presc_reg == PRESC_LAST);
    frame_end  = scan_tc && (digit_reg == DIGIT_LAST);
    presc_next = scan_tc ? '0 : presc_reg + PRESC_W'(1);
    digit_next = scan_tc ? digit_reg + DIGIT_W'(1) : digit_reg;
  end

  // Scan position registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      presc_reg <= '0;
      digit_reg <= '0;
    end else begin
      presc_reg <= presc_next;
      digit_reg <= digit_next;
    end
  end

  // ---------------------------------------------------------------------
  // Register selection
  // ---------------------------------------------------------------------
  logic [SEL_W-1:0] reg_sel_reg;
  logic             sel_changed_reg;
  logic             init_pending_reg;

  // Step the selection on each accepted press and remember that it moved,
  // so the snapshot can follow on the next cycle with the new index.
  always_ff @(posedge clock) begin
    if (!reset) begin
      reg_sel_reg      <= '0;
      sel_changed_reg  <= 1'b0;
      init_pending_reg <= 1'b1;
    end else begin
      if (press_pulse) begin
        reg_sel_reg <= reg_sel_reg + SEL_W'(1);
      end
      sel_changed_reg  <= press_pulse;
      init_pending_reg <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Snapshot
  // ---------------------------------------------------------------------
  logic [VALUE_W-1:0]  snap_reg;
  logic                snap_load;
  logic [NIBBLE_W-1:0] snap_nibble [NUM_DIGITS];

  // A frame-boundary load that coincides with a selection step is skipped:
  // the post-step load on the next cycle already picks up the new register.
  always_comb begin
    snap_load = init_pending_reg
              | sel_changed_reg
              | (frame_end & ~hold & ~press_pulse);
  end

  // Snapshot register, only ever written from the currently selected input.
  always_ff @(posedge clock) begin
    if (!reset) begin
      snap_reg <= '0;
    end else if (snap_load) begin
      snap_reg <= reg_bank[reg_sel_reg];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_nibble
      assign snap_nibble[gi] = snap_reg[gi*NIBBLE_W +: NIBBLE_W];
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Display drive
  // ---------------------------------------------------------------------
  logic [NUM_DIGITS-1:0] an_next;
  logic [6:0]            seg_next;
  logic                  dp_next;
  logic [NUM_DIGITS-1:0] an_reg;
  logic [6:0]            seg_reg;
  logic                  dp_reg;

  // Start from all anodes dark and pull only the scanned digit low.
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_anode
      assign an_next[gi] = AN_ALL_OFF[gi] ^ (digit_reg == DIGIT_W'(gi));
    end
  endgenerate

  // Segment pattern for the scanned nibble; the decimal point on the top
  // digit signals that the display is frozen.
  always_comb begin
    seg_next = hex_to_seg(snap_nibble[digit_reg]);
    dp_next  = ~(hold & (digit_reg == DIGIT_LAST));
  end

  // Anode, segments and dp are registered together so a digit switch never
  // briefly shows the neighbouring digit's segments.
  always_ff @(posedge clock) begin
    if (!reset) begin
      an_reg  <= AN_ALL_OFF ^ NUM_DIGITS'(1);
      seg_reg <= SEG_ZERO;
      dp_reg  <= 1'b1;
    end else begin
      an_reg  <= an_next;
      seg_reg <= seg_next;
      dp_reg  <= dp_next;
    end
  end

  assign an      = an_reg;
  assign seg     = seg_reg;
  assign dp      = dp_reg;
  assign reg_sel = reg_sel_reg;

endmodule

// File: tb/tb_reg_hex_display.sv
// Self-checking bench for reg_hex_display with a small scan and debounce
// setting. A cycle-level reference derived from the display rules (scan
// position from plain arithmetic, press outcomes scheduled from press times)
// is compared against every output on every cycle, plus directed checks.
module tb_reg_hex_display;

  localparam int S     = 4;
  localparam int D     = 8;
  localparam int FRAME = 4 * S;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] rv [8];
  logic        sel_btn;
  logic        hold;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [2:0]  reg_sel;

  reg_hex_display #(
    .SCAN_DIV       (S),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .r0     (rv[0]),
    .r1     (rv[1]),
    .r2     (rv[2]),
    .r3     (rv[3]),
    .r4     (rv[4]),
    .r5     (rv[5]),
    .r6     (rv[6]),
    .r7     (rv[7]),
    .sel_btn(sel_btn),
    .hold   (hold),
    .an     (an),
    .seg    (seg),
    .dp     (dp),
    .reg_sel(reg_sel)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state
  int          cyc    = 0;
  int          m_n    = 0;
  int          sched[$];
  logic [3:0]  m_an   = 4'b1110;
  logic [6:0]  m_seg  = 7'b1000000;
  logic        m_dp   = 1'b1;
  logic [2:0]  m_sel  = 3'd0;
  logic [15:0] m_snap = 16'h0000;
  bit          m_init = 1'b1;
  bit          m_chg  = 1'b0;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the reference by one clock edge using the inputs seen at that edge.
  task automatic model_step();
    int d_prev;
    bit fe;
    bit inc;
    bit ld;
    if (reset == 1'b0) begin
      m_n    = 0;
      m_sel  = 3'd0;
      m_snap = 16'h0000;
      m_init = 1'b1;
      m_chg  = 1'b0;
      m_an   = 4'b1110;
      m_seg  = 7'b1000000;
      m_dp   = 1'b1;
      sched.delete();
    end else begin
      d_prev = (m_n / S) % 4;
      fe     = ((m_n % S) == S - 1) && (d_prev == 3);
      m_an   = 4'b1111;
      m_an[d_prev] = 1'b0;
      m_seg  = glyph(m_snap[4*d_prev +: 4]);
      m_dp   = (d_prev == 3 && hold) ? 1'b0 : 1'b1;
      inc    = (sched.size() > 0) && (sched[0] == cyc);
      if (inc) void'(sched.pop_front());
      ld = m_init || m_chg || (fe && !hold && !inc);
      if (ld) m_snap = rv[m_sel];
      m_init = 1'b0;
      m_chg  = inc;
      if (inc) m_sel = m_sel + 3'd1;
      m_n++;
    end
    cyc++;
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    check("cycle", 32'({an, seg, dp, reg_sel}), 32'({m_an, m_seg, m_dp, m_sel}));
  endtask

  // Clean press: reg_sel is expected to step D+2 edges after the first edge
  // that samples the raised button (D+3 edges including that one).
  task automatic press(input int len);
    sched.push_back(cyc + D + 2);
    sel_btn = 1'b1;
    repeat (len) tick();
    sel_btn = 1'b0;
    repeat (2 * D + 4) tick();
  endtask

  task automatic glitch(input int len);
    sel_btn = 1'b1;
    repeat (len) tick();
    sel_btn = 1'b0;
    repeat (D + 4) tick();
  endtask

  // Align to the first cycle of digit 0 and check one whole frame of output.
  task automatic check_frame(input logic [15:0] val, input string tag);
    int guard = 0;
    while ((((m_n - 1) % FRAME) != 0) && (guard <= FRAME)) begin
      tick();
      guard++;
    end
    if (guard > FRAME) begin
      n_checks++;
      n_errors++;
      $error("FAIL %s_align observed=%0d expected<=%0d", tag, guard, FRAME);
    end
    for (int k = 0; k < FRAME; k++) begin
      int dg = k / S;
      check({tag, "_an"}, 32'(an), 32'(4'(~(4'b0001 << dg))));
      check({tag, "_seg"}, 32'(seg), 32'(glyph(val[4*dg +: 4])));
      check({tag, "_dp"}, 32'(dp), 32'((dg == 3 && hold) ? 1'b0 : 1'b1));
      tick();
    end
  endtask

  initial begin
    int guard;
    reset   = 1'b0;
    sel_btn = 1'b0;
    hold    = 1'b0;
    for (int i = 0; i < 8; i++) rv[i] = 16'h0000;

    // Reset state
    repeat (3) tick();
    check("rst_an", 32'(an), 32'(4'b1110));
    check("rst_seg", 32'(seg), 32'(7'b1000000));
    check("rst_dp", 32'(dp), 32'(1'b1));
    check("rst_sel", 32'(reg_sel), 32'(3'd0));
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < S; i++) begin
      tick();
      check("rst_hold_an", 32'(an), 32'(4'b1110));
      check("rst_hold_seg", 32'(seg), 32'(7'b1000000));
    end
    tick();
    check("first_adv_an", 32'(an), 32'(4'b1101));

    // Scan
    rv[0] = 16'h1A8F;
    repeat (2 * FRAME) tick();
    check_frame(16'h1A8F, "scan");
    check_frame(16'h1A8F, "scan2");

    // Debounce: short glitch ignored
    glitch(3);
    check("glitch_sel", 32'(reg_sel), 32'(3'd0));

    // 20-cycle press: step lands exactly D+3 edges after the rise
    sched.push_back(cyc + D + 2);
    sel_btn = 1'b1;
    repeat (D + 2) tick();
    check("press_early", 32'(reg_sel), 32'(3'd0));
    tick();
    check("press_lat", 32'(reg_sel), 32'(3'd1));
    repeat (20 - (D + 3)) tick();
    sel_btn = 1'b0;
    repeat (2 * D + 4) tick();

    // Seven more presses wrap to 0, then eight presses come back to 0
    for (int i = 0; i < 7; i++) begin
      rv[$urandom_range(0, 7)] = 16'($urandom);
      press($urandom_range(D, D + 6));
    end
    check("wrap7_sel", 32'(reg_sel), 32'(3'd0));
    for (int i = 0; i < 8; i++) begin
      rv[$urandom_range(0, 7)] = 16'($urandom);
      press($urandom_range(D, D + 6));
    end
    check("eight_sel", 32'(reg_sel), 32'(3'd0));

    // Hold freezes the shown value
    rv[0] = 16'h5C3D;
    repeat (2 * FRAME) tick();
    hold  = 1'b1;
    rv[0] = 16'h0000;
    repeat (3 * FRAME) tick();
    check_frame(16'h5C3D, "hold");
    hold = 1'b0;
    repeat (2 * FRAME) tick();
    check_frame(16'h0000, "unhold");

    // Selecting during hold still refreshes the snapshot
    hold  = 1'b1;
    rv[0] = 16'h1234;
    rv[1] = 16'hBEEF;
    press(D + 4);
    check("hold_sel", 32'(reg_sel), 32'(3'd1));
    check_frame(16'hBEEF, "hold_select");

    // Randomised phase: the reference checks every cycle
    for (int it = 0; it < 60; it++) begin
      rv[$urandom_range(0, 7)] = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       hold = ~hold;
        1:       rv[$urandom_range(0, 7)] = 16'($urandom);
        2:       press($urandom_range(D, D + 6));
        default: repeat ($urandom_range(1, 2 * FRAME)) tick();
      endcase
    end
    hold = 1'b0;
    if (reg_sel == 3'd0) press(D + 2);

    // Reset while digit 2 is being scanned
    guard = 0;
    while (((m_n / S) % 4) != 2 && guard <= FRAME) begin
      tick();
      guard++;
    end
    reset = 1'b0;
    tick();
    check("mid_rst_an", 32'(an), 32'(4'b1110));
    check("mid_rst_seg", 32'(seg), 32'(7'b1000000));
    check("mid_rst_sel", 32'(reg_sel), 32'(3'd0));
    reset = 1'b1;
    for (int i = 0; i < S; i++) begin
      tick();
      check("mid_rst_presc_an", 32'(an), 32'(4'b1110));
    end
    tick();
    check("mid_rst_adv_an", 32'(an), 32'(4'b1101));
    repeat (2 * FRAME) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
